// File: rtl/fib_control.sv
// Control FSM for an iterative Fibonacci datapath: loads constants, iterates while
// the datapath comparator reports work left, and holds the result until accepted.
module fib_control #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    input  logic             cmp_gt,
    input  logic             result_ready,
    output logic             sel_init,
    output logic             en_reg1,
    output logic             en_reg2,
    output logic             en_regN,
    output logic             en_count,
    output logic             busy,
    output logic             result_valid,
    output logic             result_err,
    output logic [WIDTH-1:0] iter_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] n_reg;
    logic             run_step;
    logic             en_all;

    // Result handshake: result_valid stays high from entry to DONE until the
    // cycle in which result_ready is also high; the transfer happens on that
    // edge, and result_valid/result_err/iter_count do not change before it.

    // A RUN iteration only fires while the comparator reports work left and the
    // watchdog bound has not been reached, so iter_count can never wrap.
    assign run_step = (state == RUN) && cmp_gt && (iter_count < n_reg);
    assign en_all   = (state == INIT) || run_step;

    assign en_reg1      = en_all;
    assign en_reg2      = en_all;
    assign en_regN      = en_all;
    assign en_count     = en_all;
    assign sel_init     = (state == INIT);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign state_dbg    = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            n_reg      <= '0;
            iter_count <= '0;
            result_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg      <= n_in;
                        iter_count <= '0;
                        result_err <= 1'b0;
                        state      <= INIT;
                    end
                end
                INIT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (run_step) begin
                        iter_count <= iter_count + 1'b1;
                    end else begin
                        // Comparator still high here means the watchdog tripped.
                        result_err <= cmp_gt;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_control.sv
// Directed bench for fib_control with a small datapath model driving cmp_gt.
module tb_fib_control;

    localparam int WIDTH = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] n_in;
    logic             cmp_gt;
    logic             result_ready;
    logic             sel_init;
    logic             en_reg1;
    logic             en_reg2;
    logic             en_regN;
    logic             en_count;
    logic             busy;
    logic             result_valid;
    logic             result_err;
    logic [WIDTH-1:0] iter_count;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // clock / reset
    always #5 clock = ~clock;

    fib_control #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .n_in         (n_in),
        .cmp_gt       (cmp_gt),
        .result_ready (result_ready),
        .sel_init     (sel_init),
        .en_reg1      (en_reg1),
        .en_reg2      (en_reg2),
        .en_regN      (en_regN),
        .en_count     (en_count),
        .busy         (busy),
        .result_valid (result_valid),
        .result_err   (result_err),
        .iter_count   (iter_count),
        .state_dbg    (state_dbg)
    );

    // datapath model: target loads N at INIT, count advances on each RUN step
    logic [WIDTH-1:0] dp_n      = '0;
    logic [WIDTH-1:0] dp_target = '0;
    logic [WIDTH-1:0] dp_count  = '0;
    logic             stuck     = 1'b0;

    always @(posedge clock) begin
        if (en_count) begin
            if (sel_init) begin
                dp_target <= dp_n;
                dp_count  <= '0;
            end else begin
                dp_count <= dp_count + 1'b1;
            end
        end
    end

    assign cmp_gt = stuck | (dp_target > dp_count);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    function automatic logic [3:0] en_bus();
        return {en_reg1, en_reg2, en_regN, en_count};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, " state"}, 32'(state_dbg), 32'(S_IDLE));
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " valid"}, 32'(result_valid), 0);
        check({tag, " sel"}, 32'(sel_init), 0);
        check({tag, " en"}, 32'(en_bus()), 0);
        check({tag, " iter"}, 32'(iter_count), 0);
        check({tag, " err"}, 32'(result_err), 0);
    endtask

    // One full transaction; hold = DONE cycles with result_ready low before accept.
    task automatic txn(input string tag, input int n, input bit stk, input int hold,
                       input bit busy_start, input bit exp_err);
        stuck        = stk;
        dp_n         = WIDTH'(n);
        n_in         = WIDTH'(n);
        start        = 1'b1;
        result_ready = (hold == 0);
        tick;
        start = 1'b0;
        check({tag, " init state"}, 32'(state_dbg), 32'(S_INIT));
        check({tag, " init sel"}, 32'(sel_init), 1);
        check({tag, " init en"}, 32'(en_bus()), 32'hF);
        check({tag, " init busy"}, 32'(busy), 1);
        tick;
        for (int i = 0; i < n; i++) begin
            check({tag, " run state"}, 32'(state_dbg), 32'(S_RUN));
            check({tag, " run en"}, 32'(en_bus()), 32'hF);
            check({tag, " run sel"}, 32'(sel_init), 0);
            check({tag, " run iter"}, 32'(iter_count), 32'(i));
            if (busy_start && i == 1) begin
                start = 1'b1;
                n_in  = 8'd9;
            end
            tick;
            start = 1'b0;
        end
        check({tag, " last run state"}, 32'(state_dbg), 32'(S_RUN));
        check({tag, " last run en"}, 32'(en_bus()), 0);
        check({tag, " last run valid"}, 32'(result_valid), 0);
        tick;
        for (int h = 0; h < ((hold == 0) ? 1 : hold); h++) begin
            if (h > 0) tick;
            check({tag, " done state"}, 32'(state_dbg), 32'(S_DONE));
            check({tag, " done valid"}, 32'(result_valid), 1);
            check({tag, " done iter"}, 32'(iter_count), 32'(n));
            check({tag, " done err"}, 32'(result_err), 32'(exp_err));
            check({tag, " done en"}, 32'(en_bus()), 0);
            check({tag, " done busy"}, 32'(busy), 1);
        end
        // accept, with a start in the same cycle that must not be taken
        result_ready = 1'b1;
        start        = 1'b1;
        n_in         = 8'd7;
        tick;
        start = 1'b0;
        check({tag, " idle state"}, 32'(state_dbg), 32'(S_IDLE));
        check({tag, " idle busy"}, 32'(busy), 0);
        check({tag, " idle valid"}, 32'(result_valid), 0);
        tick;
        check({tag, " still idle"}, 32'(state_dbg), 32'(S_IDLE));
        stuck = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        n_in         = '0;
        result_ready = 1'b0;
        tick;
        tick;
        check_quiet("reset");
        reset = 1'b0;
        tick;

        txn("normal5", 5, 1'b0, 0, 1'b0, 1'b0);
        txn("n0", 0, 1'b0, 0, 1'b0, 1'b0);
        txn("bp2", 2, 1'b0, 4, 1'b0, 1'b0);
        txn("stuck3", 3, 1'b1, 0, 1'b0, 1'b1);
        txn("busystart4", 4, 1'b0, 0, 1'b1, 1'b0);

        // reset during the second RUN cycle, with start raised alongside it
        dp_n  = 8'd5;
        n_in  = 8'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        check("mid reset pre state", 32'(state_dbg), 32'(S_RUN));
        check("mid reset pre iter", 32'(iter_count), 1);
        reset = 1'b1;
        start = 1'b1;
        tick;
        check_quiet("mid reset");
        reset = 1'b0;
        start = 1'b0;
        tick;
        check("post reset idle", 32'(state_dbg), 32'(S_IDLE));

        txn("after reset n1", 1, 1'b0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
